piso_frame_serializer: RTL and testbench

Parametrised parallel-in/serial-out frame serializer for the spectrogram output path. It accepts one frame of NUM_CH channel words (for example, per-band magnitudes) through a valid/ready handshake and shifts them out one bit per enabled cycle. Bit order is selectable, and frame/channel markers are provided. Back-to-back frames are seamless, and the pin-level serial rate is throttled by an external strobe.

---
 rtl/spectro_pkg.sv | 17 +
 rtl/frame_bit_counter.sv | 56 +++++
 rtl/piso_frame_serializer.sv | 111 +++++++++++
 tb/tb_piso_frame_serializer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/spectro_pkg.sv
// Shared definitions for the spectrogram output path: state encoding and width helper.
package spectro_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_e;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Nested bit/channel position counter for one serial frame.
module frame_bit_counter
  import spectro_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr_i,
  input  logic                            en_i,
  output logic                            last_bit_c_o,
  output logic [clog2_min1(NUM_CH)-1:0]   ch_idx_o
);

  localparam int unsigned BIT_W = clog2_min1(DATA_W);
  localparam int unsigned CH_W  = clog2_min1(NUM_CH);

  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             bit_end_c;
  logic             ch_end_c;

  assign bit_end_c    = (bit_q == BIT_W'(DATA_W - 1));
  assign ch_end_c     = (ch_q == CH_W'(NUM_CH - 1));
  assign last_bit_c_o = bit_end_c & ch_end_c;
  assign ch_idx_o     = ch_q;

  // Clear wins over enable; the channel wraps with the bit so the frame end lands on 0/0.
  always_comb begin
    bit_d = bit_q;
    ch_d  = ch_q;
    if (clr_i) begin
      bit_d = '0;
      ch_d  = '0;
    end else if (en_i) begin
      if (bit_end_c) begin
        bit_d = '0;
        ch_d  = ch_end_c ? '0 : ch_q + CH_W'(1);
      end else begin
        bit_d = bit_q + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= '0;
      ch_q  <= '0;
    end else begin
      bit_q <= bit_d;
      ch_q  <= ch_d;
    end
  end

endmodule

// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame serializer with valid/ready intake and strobe-paced shifting.
module piso_frame_serializer
  import spectro_pkg::*;
#(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned NUM_CH    = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH*DATA_W-1:0]       in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           shift_en,
  output logic                           ser_out,
  output logic                           ser_valid,
  output logic                           frame_start,
  output logic [clog2_min1(NUM_CH)-1:0]  ch_idx,
  output logic                           busy
);

  localparam int unsigned FRAME_W = NUM_CH * DATA_W;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic                 ser_out_q, ser_out_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 frame_start_q, frame_start_d;
  logic [FRAME_W-1:0]   frame_ord;
  logic                 cnt_clr, cnt_en;
  logic                 cnt_last_c;
  logic                 last_bit_c;
  logic                 accept_c;

  // Reorder the incoming frame into transmit order so the shadow just shifts right.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
      localparam int unsigned SRC = MSB_FIRST ? (DATA_W - 1 - b) : b;
      assign frame_ord[k*DATA_W + b] = in_data[k*DATA_W + SRC];
    end
  end

  frame_bit_counter #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cnt_clr),
    .en_i         (cnt_en),
    .last_bit_c_o (cnt_last_c),
    .ch_idx_o     (ch_idx)
  );

  assign last_bit_c = (state_q == S_SHIFT) & cnt_last_c;
  assign in_ready   = rst_n & ((state_q == S_IDLE) | (last_bit_c & shift_en));
  assign accept_c   = in_valid & in_ready;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = frame_start_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    if (accept_c) begin
      state_d       = S_SHIFT;
      shadow_d      = frame_ord;
      ser_out_d     = frame_ord[0];
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      cnt_clr       = 1'b1;
    end else if ((state_q == S_SHIFT) && shift_en) begin
      if (cnt_last_c) begin
        state_d       = S_IDLE;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        cnt_clr       = 1'b1;
      end else begin
        shadow_d      = shadow_q >> 1;
        ser_out_d     = shadow_q[1];
        frame_start_d = 1'b0;
        cnt_en        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shadow_q      <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == S_SHIFT);

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Randomized bench for piso_frame_serializer: LSB-first and MSB-first instances against a frame-level model.
module tb_piso_frame_serializer;

  localparam int unsigned DW = 12;
  localparam int unsigned NC = 2;
  localparam int unsigned F  = DW * NC;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [F-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic       rdy0, so0, sv0, fs0, bz0;
  logic [0:0] ci0;
  logic       rdy1, so1, sv1, fs1, bz1;
  logic [0:0] ci1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit m_active = 1'b0;
  int m_pos    = 0;
  bit m_bits0[F];
  bit m_bits1[F];

  logic last_so0, last_so1;

  always #5 clk = ~clk;

  piso_frame_serializer #(.DATA_W(DW), .NUM_CH(NC), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .shift_en(shift_en), .ser_out(so0), .ser_valid(sv0), .frame_start(fs0),
    .ch_idx(ci0), .busy(bz0)
  );

  piso_frame_serializer #(.DATA_W(DW), .NUM_CH(NC), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .shift_en(shift_en), .ser_out(so1), .ser_valid(sv1), .frame_start(fs1),
    .ch_idx(ci1), .busy(bz1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Transmit order: channel 0 first, bits within a word LSB-first (dut0) or MSB-first (dut1).
  task automatic load_model(input logic [F-1:0] d);
    for (int i = 0; i < int'(F); i++) begin
      int ch, b;
      ch = i / int'(DW);
      b  = i % int'(DW);
      m_bits0[i] = d[ch*int'(DW) + b];
      m_bits1[i] = d[ch*int'(DW) + int'(DW) - 1 - b];
    end
  endtask

  task automatic step(input bit r, input bit v, input bit se, input logic [F-1:0] d);
    bit rdy_exp, acc;
    @(negedge clk);
    rst_n = r; in_valid = v; shift_en = se; in_data = d;
    cyc++;
    if (!r) m_active = 1'b0;
    #1;
    rdy_exp = r && (!m_active || (m_pos == int'(F) - 1 && se));
    chk("in_ready0",    32'(rdy0), 32'(rdy_exp));
    chk("in_ready1",    32'(rdy1), 32'(rdy_exp));
    chk("ser_valid0",   32'(sv0),  32'(m_active));
    chk("ser_valid1",   32'(sv1),  32'(m_active));
    chk("ser_out0",     32'(so0),  32'(m_active ? m_bits0[m_pos] : 1'b0));
    chk("ser_out1",     32'(so1),  32'(m_active ? m_bits1[m_pos] : 1'b0));
    chk("frame_start0", 32'(fs0),  32'(m_active && m_pos == 0));
    chk("frame_start1", 32'(fs1),  32'(m_active && m_pos == 0));
    chk("ch_idx0",      32'(ci0),  m_active ? 32'(m_pos / int'(DW)) : 32'd0);
    chk("ch_idx1",      32'(ci1),  m_active ? 32'(m_pos / int'(DW)) : 32'd0);
    chk("busy0",        32'(bz0),  32'(m_active));
    chk("busy1",        32'(bz1),  32'(m_active));
    last_so0 = so0;
    last_so1 = so1;
    acc = v && rdy_exp;
    @(posedge clk);
    if (r) begin
      if (m_active && se) begin
        if (m_pos == int'(F) - 1) begin
          if (acc) begin
            load_model(d);
            m_pos = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_pos++;
        end
      end else if (!m_active && acc) begin
        load_model(d);
        m_pos    = 0;
        m_active = 1'b1;
      end
    end
  endtask

  initial begin
    logic [F-1:0]  frame_a;
    logic [DW-1:0] w0, w1;
    frame_a = {12'h123, 12'hA5C};
    w0 = '0;
    w1 = '0;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 24'($urandom));

    // Known frame, shift_en tied high, single offer
    step(1'b1, 1'b1, 1'b1, frame_a);
    for (int i = 0; i < int'(DW); i++) begin
      step(1'b1, 1'b0, 1'b1, 24'($urandom));
      w0[i]          = last_so0;
      w1[DW - 1 - i] = last_so1;
    end
    chk("lsb_word_ch0", 32'(w0), 32'h0A5C);
    chk("msb_word_ch0", 32'(w1), 32'h0A5C);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 24'($urandom));

    // Strobe every third cycle, new offer mid-frame must be ignored
    step(1'b1, 1'b1, 1'b1, 24'($urandom));
    for (int i = 0; i < 90; i++)
      step(1'b1, (i >= 20 && i < 30), (i % 3 == 2), 24'($urandom));

    // Back-to-back frames with in_valid held high
    for (int i = 0; i < 52; i++) step(1'b1, 1'b1, 1'b1, 24'($urandom));
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 24'($urandom));

    // Reset at bit 7 of a frame, then a clean restart
    step(1'b1, 1'b1, 1'b1, 24'($urandom));
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 24'($urandom));
    step(1'b0, 1'b1, 1'b1, 24'($urandom));
    step(1'b0, 1'b0, 1'b0, 24'($urandom));
    step(1'b1, 1'b1, 1'b1, 24'($urandom));
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 24'($urandom));

    // Random traffic, strobe and occasional reset
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) < 7), 24'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
